// File: rtl/ddr_tx_serializer_if.sv
// Word-level valid/ready handshake between a producer and the DDR serializer.
interface ddr_tx_serializer_if #(
  parameter int W = 16
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ddr_tx_serializer.sv
// Serializes W-bit words into 2-bit beats for a data ODDR, with a word-start
// marker for a companion frame ODDR. One word of holding buffer keeps words gapless.
module ddr_tx_serializer #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                c,
  input  logic                rst_n,
  ddr_tx_serializer_if.slave  up,
  output logic [1:0]          d,
  output logic [1:0]          f,
  output logic                busy,
  output logic                underrun
);
  localparam int NBEATS = W / 2;
  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    hold_q, hold_d;
  logic            hold_v_q, hold_v_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      d_q, d_d;
  logic [1:0]      f_q, f_d;
  logic            busy_q, busy_d;
  logic            underrun_q, underrun_d;
  logic            in_ready_q, in_ready_d;
  logic            accept_s;
  logic            load_s;

  // The bit pair that goes out next; d[0] leaves on the C0 half.
  function automatic logic [1:0] next_beat(input logic [W-1:0] w);
    if (MSB_FIRST) begin
      next_beat = {w[W-2], w[W-1]};
    end else begin
      next_beat = w[1:0];
    end
  endfunction

  function automatic logic [W-1:0] drop_beat(input logic [W-1:0] w);
    if (MSB_FIRST) begin
      drop_beat = {w[W-3:0], 2'b00};
    end else begin
      drop_beat = {2'b00, w[W-1:2]};
    end
  endfunction

  // Next-state logic for holding register, shifter and registered outputs.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    d_d        = {2{IDLE_BIT}};
    f_d        = 2'b00;
    underrun_d = 1'b0;
    load_s     = 1'b0;
    accept_s   = up.in_valid & in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (hold_v_q) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BEAT) begin
          if (hold_v_q) begin
            load_s = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          d_d   = next_beat(sr_q);
          sr_d  = drop_beat(sr_q);
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Loading emits beat 0 straight from hold so the word starts one edge after it is seen.
    if (load_s) begin
      state_d  = ST_SHIFT;
      d_d      = next_beat(hold_q);
      f_d      = 2'b11;
      sr_d     = drop_beat(hold_q);
      cnt_d    = '0;
      hold_v_d = 1'b0;
    end else begin
      hold_v_d = hold_v_d;
    end

    if (accept_s) begin
      hold_d   = up.in_data;
      hold_v_d = 1'b1;
    end else begin
      hold_d   = hold_d;
    end

    in_ready_d = ~hold_v_d;
    busy_d     = (state_d == ST_SHIFT);
  end

  // State and output registers.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      d_q        <= {2{IDLE_BIT}};
      f_q        <= 2'b00;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      f_q        <= f_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign d           = d_q;
  assign f           = f_q;
  assign busy        = busy_q;
  assign underrun    = underrun_q;
  assign up.in_ready = in_ready_q;

endmodule
